mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, master/memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, write/read data width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have, per master n in {0,1}, ports mn_req (in, 1, access request), mn_addr (in, ADDR_W), mn_wen (in, 1, 1=write, 0=read), mn_wdata (in, DATA_W), mn_read_type (in, 3, access size/sign code, passed through), mn_gnt (out, 1, access accepted this cycle), mn_rvalid (out, 1, read data valid), mn_rdata (out, DATA_W).
REQ-006 SHALL have memory-side ports memory_addr (out, ADDR_W), memory_write_en (out, 1), memory_write_data (out, DATA_W), memory_read_type (out, 3), memory_read_data (in, DATA_W, valid one cycle after address).
REQ-007 Master 0 SHALL be the CPU data path from the system bus; master 1 SHALL be a DMA/video fetch requester.

Function
REQ-008 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; mn_gnt is combinational from mn_req and arbiter state.
REQ-009 Exactly one request high SHALL be granted in the same cycle.
REQ-010 Both requests high SHALL grant the master not recorded in register last_gnt (round-robin); last_gnt updates to the granted master at the clock edge.
REQ-011 Memory-side outputs SHALL be combinationally muxed from the granted master; no grant SHALL drive memory_write_en=0, memory_addr/data/read_type=0.
REQ-012 memory_write_en SHALL equal mn_wen only for the granted master, never for an ungranted one.
REQ-013 A granted read SHALL set register rd_owner and pulse mn_rvalid for exactly one cycle, the cycle after grant, with mn_rdata=memory_read_data; the other master's rvalid SHALL stay 0.
REQ-014 Granted writes SHALL produce no rvalid.
REQ-015 mn_rdata SHALL be 0 when mn_rvalid is 0.
REQ-016 A requester SHALL hold req/addr/wen/wdata/read_type stable until its gnt; the arbiter does not latch ungranted requests.
REQ-017 Back-to-back grants SHALL be allowed every cycle, sustaining one access per cycle; read-after-read from different masters returns data in issue order.
REQ-018 Starvation counter: a master requesting but not granted for 2 consecutive cycles SHALL be granted on the next cycle regardless of last_gnt.

Reset
REQ-019 Reset SHALL force last_gnt=1 (master 0 wins first contention), rd_owner cleared, m0_rvalid=m1_rvalid=0, starvation counters=0.
REQ-020 While reset is high, m0_gnt, m1_gnt and memory_write_en SHALL be 0.
REQ-021 Reset asserted in the cycle after a read grant SHALL suppress that rvalid.

Configuration
REQ-022 Macro MEM_ARBITER_FIXED_PRIO_EN defined: master 0 always wins contention, last_gnt and starvation logic are removed (REQ-010, REQ-018 do not apply).
REQ-023 Macro undefined: round-robin with starvation counter per REQ-010/REQ-018.

Structure
REQ-024 Master index encoding (MASTER_CPU=0, MASTER_DMA=1) and read_type codes SHALL live in the shared bus package used by the system bus.
REQ-025 The block SHALL be a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-026 Only m0 reads addr 0x10 -> m0_gnt same cycle, memory_addr=0x10, m0_rvalid next cycle with memory contents.
REQ-027 After reset both request (m0 read 0x20, m1 read 0x40) -> m0 granted cycle 1, m1 cycle 2, rvalids in that order with correct data.
REQ-028 Both hold requests 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1 (round-robin); with FIXED_PRIO macro -> m0 all 6, m1 none.
REQ-029 m1 writes 0xDEADBEEF to 0x30 while m0 idle -> memory_write_en=1 one cycle, no rvalid; m0 read 0x30 next -> rdata=0xDEADBEEF.
REQ-030 Reset asserted the cycle after an m1 read grant -> m1_rvalid stays 0, gnts 0 during reset, m0 wins first post-reset contention.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions: master indices, read_type size/sign codes and arbiter constants.
// Consumed by mem_arbiter and by the system bus that drives master 0.
package mem_arbiter_pkg;

    localparam int unsigned READ_TYPE_W = 3;
    localparam int unsigned STARVE_W    = 2;

    // A requester refused this many consecutive cycles wins the next one outright.
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(2);

    typedef enum logic {
        MASTER_CPU = 1'b0,
        MASTER_DMA = 1'b1
    } master_e;

    typedef enum logic [READ_TYPE_W-1:0] {
        RT_BYTE   = 3'b000,
        RT_HALF   = 3'b001,
        RT_WORD   = 3'b010,
        RT_BYTE_U = 3'b100,
        RT_HALF_U = 3'b101
    } read_type_e;

    function automatic master_e other_master(input master_e m);
        return (m == MASTER_CPU) ? MASTER_DMA : MASTER_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master single-port memory arbiter: combinational grant and memory mux, one-cycle read return.
// Define MEM_ARBITER_FIXED_PRIO_EN for fixed master-0 priority (no round-robin, no starvation counters).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic                   m0_req,
    input  logic [ADDR_W-1:0]      m0_addr,
    input  logic                   m0_wen,
    input  logic [DATA_W-1:0]      m0_wdata,
    input  logic [READ_TYPE_W-1:0] m0_read_type,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [DATA_W-1:0]      m0_rdata,

    input  logic                   m1_req,
    input  logic [ADDR_W-1:0]      m1_addr,
    input  logic                   m1_wen,
    input  logic [DATA_W-1:0]      m1_wdata,
    input  logic [READ_TYPE_W-1:0] m1_read_type,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [DATA_W-1:0]      m1_rdata,

    output logic [ADDR_W-1:0]      memory_addr,
    output logic                   memory_write_en,
    output logic [DATA_W-1:0]      memory_write_data,
    output logic [READ_TYPE_W-1:0] memory_read_type,
    input  logic [DATA_W-1:0]      memory_read_data
);

    logic    rd_pending;
    master_e rd_owner;

`ifndef MEM_ARBITER_FIXED_PRIO_EN
    master_e             last_gnt;
    logic [STARVE_W-1:0] starve0;
    logic [STARVE_W-1:0] starve1;
    logic [STARVE_W-1:0] starve0_nxt;
    logic [STARVE_W-1:0] starve1_nxt;
`endif

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (m0_req && !m1_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req && !m0_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
                m0_gnt = 1'b1;
`else
                if (starve0 == STARVE_LIMIT) begin
                    m0_gnt = 1'b1;
                end else if (starve1 == STARVE_LIMIT) begin
                    m1_gnt = 1'b1;
                end else if (other_master(last_gnt) == MASTER_CPU) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
`endif
            end
        end
    end

`ifndef MEM_ARBITER_FIXED_PRIO_EN
    // Consecutive refused-request counters, saturating at the limit.
    always_comb begin
        starve0_nxt = '0;
        starve1_nxt = '0;
        if (m0_req && !m0_gnt) begin
            starve0_nxt = (starve0 == STARVE_LIMIT) ? starve0 : starve0 + STARVE_W'(1);
        end
        if (m1_req && !m1_gnt) begin
            starve1_nxt = (starve1 == STARVE_LIMIT) ? starve1 : starve1 + STARVE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt <= MASTER_DMA;
            starve0  <= '0;
            starve1  <= '0;
        end else begin
            starve0 <= starve0_nxt;
            starve1 <= starve1_nxt;
            if (m0_gnt) begin
                last_gnt <= MASTER_CPU;
            end else if (m1_gnt) begin
                last_gnt <= MASTER_DMA;
            end
        end
    end
`endif

    // Memory port follows the granted master; idle bus is all zeros.
    always_comb begin
        memory_addr       = '0;
        memory_write_en   = 1'b0;
        memory_write_data = '0;
        memory_read_type  = '0;
        if (m0_gnt) begin
            memory_addr       = m0_addr;
            memory_write_en   = m0_wen;
            memory_write_data = m0_wdata;
            memory_read_type  = m0_read_type;
        end else if (m1_gnt) begin
            memory_addr       = m1_addr;
            memory_write_en   = m1_wen;
            memory_write_data = m1_wdata;
            memory_read_type  = m1_read_type;
        end
    end

    // Remember who issued the read so the next-cycle memory data is steered back to it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= MASTER_CPU;
        end else begin
            rd_pending <= (m0_gnt && !m0_wen) || (m1_gnt && !m1_wen);
            if (m0_gnt && !m0_wen) begin
                rd_owner <= MASTER_CPU;
            end else if (m1_gnt && !m1_wen) begin
                rd_owner <= MASTER_DMA;
            end
        end
    end

    always_comb begin
        m0_rvalid = rd_pending && (rd_owner == MASTER_CPU);
        m1_rvalid = rd_pending && (rd_owner == MASTER_DMA);
        m0_rdata  = m0_rvalid ? memory_read_data : '0;
        m1_rdata  = m1_rvalid ? memory_read_data : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants checked inline, read returns checked by a scoreboard monitor.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          m0_req, m0_wen, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [2:0]    m0_read_type;
    logic          m1_req, m1_wen, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [2:0]    m1_read_type;
    logic [AW-1:0] memory_addr;
    logic          memory_write_en;
    logic [DW-1:0] memory_write_data, memory_read_data;
    logic [2:0]    memory_read_type;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          who;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic [DW-1:0] mem [256];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
        .m0_read_type(m0_read_type), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
        .m1_read_type(m1_read_type), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .memory_addr(memory_addr), .memory_write_en(memory_write_en),
        .memory_write_data(memory_write_data), .memory_read_type(memory_read_type),
        .memory_read_data(memory_read_data)
    );

    always #5 clock = ~clock;

    // Synchronous memory model: read data appears the cycle after the address.
    always @(posedge clock) begin
        if (memory_write_en) mem[memory_addr[7:0]] <= memory_write_data;
        memory_read_data <= mem[memory_addr[7:0]];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic expect_read(input logic who, input logic [DW-1:0] d);
        exp_t e;
        e.who  = who;
        e.data = d;
        sb.push_back(e);
    endtask

    // Read-return monitor.
    always @(negedge clock) begin
        if (!m0_rvalid) check("m0_rdata_zero", 64'(m0_rdata), 64'd0);
        if (!m1_rvalid) check("m1_rdata_zero", 64'(m1_rdata), 64'd0);
        if (m0_rvalid && m1_rvalid) begin
            tests++;
            fails++;
            $display("FAIL both_rvalid: got m0=1 m1=1 expected at most one");
        end else if (m0_rvalid || m1_rvalid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got m0=%0b m1=%0b expected none", m0_rvalid, m1_rvalid);
            end else begin
                mon_e = sb.pop_front();
                check("rvalid_owner", 64'(m1_rvalid), 64'(mon_e.who));
                check("rdata", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(mon_e.data));
            end
        end
    end

    task automatic drive0(input logic req, input logic [AW-1:0] a, input logic wen,
                          input logic [DW-1:0] wd, input logic [2:0] rt);
        m0_req = req; m0_addr = a; m0_wen = wen; m0_wdata = wd; m0_read_type = rt;
    endtask

    task automatic drive1(input logic req, input logic [AW-1:0] a, input logic wen,
                          input logic [DW-1:0] wd, input logic [2:0] rt);
        m1_req = req; m1_addr = a; m1_wen = wen; m1_wdata = wd; m1_read_type = rt;
    endtask

    task automatic idle();
        drive0(1'b0, '0, 1'b0, '0, 3'b000);
        drive1(1'b0, '0, 1'b0, '0, 3'b000);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic check_gnt(input string nm, input logic g0, input logic g1);
        check({nm, "_m0_gnt"}, 64'(m0_gnt), 64'(g0));
        check({nm, "_m1_gnt"}, 64'(m1_gnt), 64'(g1));
    endtask

    // Reset with both masters requesting (m0 writing), then one idle cycle.
    task automatic do_reset();
        reset = 1'b1;
        drive0(1'b1, 32'h8, 1'b1, 32'h55, 3'(RT_WORD));
        drive1(1'b1, 32'h9, 1'b0, 32'h0, 3'(RT_WORD));
        @(negedge clock);
        check_gnt("in_reset", 1'b0, 1'b0);
        check("in_reset_wen", 64'(memory_write_en), 64'd0);
        check("in_reset_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        advance();
        reset = 1'b0;
        idle();
        @(negedge clock);
        check_gnt("idle", 1'b0, 1'b0);
        check("idle_addr", 64'(memory_addr), 64'd0);
        check("idle_wen", 64'(memory_write_en), 64'd0);
        advance();
    endtask

    initial begin
        logic exp1;
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | DW'(i);
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Contention straight after reset: m0 first, then m1.
        drive0(1'b1, 32'h20, 1'b0, '0, 3'(RT_WORD));
        drive1(1'b1, 32'h40, 1'b0, '0, 3'(RT_WORD));
        @(negedge clock);
        check_gnt("first_contention", 1'b1, 1'b0);
        check("first_contention_addr", 64'(memory_addr), 64'h20);
        expect_read(1'b0, 32'hA500_0020);
        advance();
        drive0(1'b0, '0, 1'b0, '0, 3'b000);
        @(negedge clock);
        check_gnt("second_grant", 1'b0, 1'b1);
        check("second_grant_addr", 64'(memory_addr), 64'h40);
        expect_read(1'b1, 32'hA500_0040);
        advance();
        idle();
        advance();

        // Lone m0 read with read_type passthrough.
        drive0(1'b1, 32'h10, 1'b0, '0, 3'(RT_HALF_U));
        @(negedge clock);
        check_gnt("solo_read", 1'b1, 1'b0);
        check("solo_read_addr", 64'(memory_addr), 64'h10);
        check("solo_read_rt", 64'(memory_read_type), 64'(RT_HALF_U));
        check("solo_read_wen", 64'(memory_write_en), 64'd0);
        expect_read(1'b0, 32'hA500_0010);
        advance();
        idle();
        advance();

        // Sustained contention for six cycles.
        do_reset();
        drive0(1'b1, 32'h01, 1'b0, '0, 3'(RT_WORD));
        drive1(1'b1, 32'h02, 1'b0, '0, 3'(RT_WORD));
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            exp1 = 1'b0;
`else
            exp1 = i[0];
`endif
            @(negedge clock);
            check_gnt("hold", ~exp1, exp1);
            check("hold_addr", 64'(memory_addr), exp1 ? 64'h02 : 64'h01);
            check("hold_wen", 64'(memory_write_en), 64'd0);
            expect_read(exp1, exp1 ? 32'hA500_0002 : 32'hA500_0001);
            advance();
        end
        idle();
        advance();

        // m1 write, then m0 reads it back.
        drive1(1'b1, 32'h30, 1'b1, 32'hDEAD_BEEF, 3'(RT_WORD));
        @(negedge clock);
        check_gnt("m1_write", 1'b0, 1'b1);
        check("m1_write_en", 64'(memory_write_en), 64'd1);
        check("m1_write_addr", 64'(memory_addr), 64'h30);
        check("m1_write_data", 64'(memory_write_data), 64'hDEAD_BEEF);
        advance();
        idle();
        drive0(1'b1, 32'h30, 1'b0, '0, 3'(RT_WORD));
        @(negedge clock);
        check_gnt("readback", 1'b1, 1'b0);
        check("readback_wen", 64'(memory_write_en), 64'd0);
        expect_read(1'b0, 32'hDEAD_BEEF);
        advance();
        idle();
        repeat (2) advance();

        // Reset lands the cycle after an m1 read grant.
        do_reset();
        drive1(1'b1, 32'h40, 1'b0, '0, 3'(RT_WORD));
        @(negedge clock);
        check_gnt("pre_reset_read", 1'b0, 1'b1);
        advance();
        reset = 1'b1;
        drive0(1'b1, 32'h20, 1'b1, 32'h77, 3'(RT_WORD));
        drive1(1'b1, 32'h40, 1'b0, '0, 3'(RT_WORD));
        @(negedge clock);
        check("killed_rvalid", 64'(m1_rvalid), 64'd0);
        check_gnt("mid_reset", 1'b0, 1'b0);
        check("mid_reset_wen", 64'(memory_write_en), 64'd0);
        advance();
        reset = 1'b0;
        drive0(1'b1, 32'h20, 1'b0, '0, 3'(RT_WORD));
        @(negedge clock);
        check_gnt("post_reset", 1'b1, 1'b0);
        expect_read(1'b0, 32'hA500_0020);
        advance();
        drive0(1'b0, '0, 1'b0, '0, 3'b000);
        @(negedge clock);
        check_gnt("post_reset_m1", 1'b0, 1'b1);
        expect_read(1'b1, 32'hA500_0040);
        advance();
        idle();

        for (int i = 0; i < 10 && sb.size() != 0; i++) advance();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        advance();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
